// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end.
//   state_e        : frame FSM states
//   FRAME_BITS_DEF : default command frame width (2 cmd + 8 payload)
//   DATA_BITS_DEF  : default read-data width shifted out on MISO
//   WR_ADDR..RD_DATA : command codes carried in rx_data[9:8]
package spi_pkg;

    localparam int FRAME_BITS_DEF = 10;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/spi_miso_shifter.sv
// MISO serialiser for read data.
//   clk, rst  : clock, synchronous active-high reset
//   abort     : cancels any pending or active shift-out
//   arm       : one-cycle pulse, start waiting for tx_valid
//   tx_valid  : load strobe, honoured only while armed
//   tx_data   : word to serialise, MSB first
//   miso      : serial output, 0 whenever not shifting
//   done      : high in the cycle the last bit is on miso
module spi_miso_shifter
    import spi_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 abort,
    input  logic                 arm,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 miso,
    output logic                 done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

    logic                 armed_q, armed_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        armed_d = armed_q;
        busy_d  = busy_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (abort) begin
            armed_d = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            if (arm) begin
                armed_d = 1'b1;
            end
            // Only the first tx_valid after arming is taken; later pulses
            // find armed_q already cleared.
            if (armed_q && tx_valid) begin
                armed_d = 1'b0;
                busy_d  = 1'b1;
                sh_d    = tx_data;
                cnt_d   = '0;
            end else if (busy_q) begin
                sh_d  = {sh_q[DATA_BITS-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    busy_d = 1'b0;
                    done   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            busy_q  <= busy_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // The loaded word's MSB appears the cycle after the load edge.
    assign miso = busy_q & sh_q[DATA_BITS-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end between the SPI pins and the dual-port RAM.
//   clk, rst : SPI clock, synchronous active-high reset
//   SS_n     : slave select, active low; high aborts any frame
//   MOSI     : serial command input, MSB first
//   MISO     : serial read-data output, MSB first
//   rx_data  : assembled command word {cmd[1:0], payload}
//   rx_valid : one-cycle strobe qualifying rx_data
//   tx_data  : read data from the RAM
//   tx_valid : RAM strobe qualifying tx_data
// Handshake: rx_valid is a single-cycle push with no back-pressure;
// tx_valid is a single-cycle push accepted only while a read is armed.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_BITS-1:0]  tx_data,
    input  logic                  tx_valid
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rd_addr_seen_q, rd_addr_seen_d;
    // Set once a full frame has been taken in this SS_n-low period so that
    // further bits are ignored until the return through IDLE.
    logic                  frame_done_q, frame_done_d;
    logic                  tx_arm;
    logic                  tx_done;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        frame_done_d   = frame_done_q;
        tx_arm         = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d    = '0;
                frame_done_d = 1'b0;
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], MOSI};
                    bit_cnt_d = CNT_W'(1);
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (!rd_addr_seen_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end
            end
            default: begin
                if (SS_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (!frame_done_q) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], MOSI};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST) begin
                        rx_data_d    = {shift_q[FRAME_BITS-2:0], MOSI};
                        rx_valid_d   = 1'b1;
                        frame_done_d = 1'b1;
                        if (state_q == READ_ADD) begin
                            rd_addr_seen_d = 1'b1;
                        end
                        if (state_q == READ_DATA) begin
                            tx_arm = 1'b1;
                        end
                    end
                end
            end
        endcase

        // Completed read-data shift-out consumes the stored read address.
        if (tx_done) begin
            rd_addr_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            frame_done_q   <= frame_done_d;
        end
    end

    spi_miso_shifter #(
        .DATA_BITS(DATA_BITS)
    ) u_miso_shifter (
        .clk     (clk),
        .rst     (rst),
        .abort   (SS_n),
        .arm     (tx_arm),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .miso    (MISO),
        .done    (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks;
  int errors;

  state_e route;
  int     early_valid;
  int     miso_bad;

  spi_slave_if dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (ss_n),
    .MOSI    (mosi),
    .MISO    (miso),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select, then shift one frame MSB first. Leaves the bench #1 after the
  // edge that sampled bit 0, with SS_n still low.
  task automatic send_frame(input logic [9:0] f);
    early_valid = 0;
    miso_bad    = 0;
    ss_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      mosi = f[i];
      if (rx_valid) early_valid++;
      if (miso) miso_bad++;
      tick();
      if (i == 9) route = dut.state_q;
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, IDLE); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data got %h exp 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (dut.bit_cnt_q !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d exp 0", dut.bit_cnt_q); end
    checks++; if (dut.rd_addr_seen_q !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_seen got %b exp 0", dut.rd_addr_seen_q); end
  endtask

  task automatic test_write_addr();
    int late_valid;
    send_frame(10'b00_1010_0101);
    checks++; if (route !== WRITE) begin errors++; $display("FAIL wa_route got %0d exp %0d", route, WRITE); end
    checks++; if (early_valid !== 0) begin errors++; $display("FAIL wa_early_valid got %0d exp 0", early_valid); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wa_rx_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL wa_rx_data got %h exp 0a5", rx_data); end
    mosi = 1'b1;
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wa_valid_one_cycle got %b exp 0", rx_valid); end
    // extra bits beyond the frame must be ignored
    late_valid = 0;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom_range(0, 1));
      if (miso) miso_bad++;
      tick();
      if (rx_valid) late_valid++;
    end
    checks++; if (late_valid !== 0) begin errors++; $display("FAIL wa_extra_bits_valid got %0d exp 0", late_valid); end
    checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL wa_rx_data_hold got %h exp 0a5", rx_data); end
    checks++; if (miso_bad !== 0) begin errors++; $display("FAIL wa_miso got %0d high cycles exp 0", miso_bad); end
    end_frame();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL wa_idle got %0d exp %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_write_data();
    send_frame(10'b01_0011_1100);
    checks++; if (route !== WRITE) begin errors++; $display("FAIL wd_route got %0d exp %0d", route, WRITE); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wd_rx_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 10'h13C) begin errors++; $display("FAIL wd_rx_data got %h exp 13c", rx_data); end
    checks++; if (dut.rd_addr_seen_q !== 1'b0) begin errors++; $display("FAIL wd_rd_addr_seen got %b exp 0", dut.rd_addr_seen_q); end
    end_frame();
  endtask

  task automatic test_read();
    logic [7:0] exp_bits;
    exp_bits = 8'hC3;
    send_frame(10'b10_0000_0111);
    checks++; if (route !== READ_ADD) begin errors++; $display("FAIL ra_route got %0d exp %0d", route, READ_ADD); end
    checks++; if (rx_data !== 10'h207) begin errors++; $display("FAIL ra_rx_data got %h exp 207", rx_data); end
    end_frame();
    checks++; if (dut.rd_addr_seen_q !== 1'b1) begin errors++; $display("FAIL ra_rd_addr_seen got %b exp 1", dut.rd_addr_seen_q); end
    send_frame(10'b11_0101_0101);
    checks++; if (route !== READ_DATA) begin errors++; $display("FAIL rd_route got %0d exp %0d", route, READ_DATA); end
    checks++; if (rx_data !== 10'h355) begin errors++; $display("FAIL rd_rx_data got %h exp 355", rx_data); end
    checks++; if (miso_bad !== 0) begin errors++; $display("FAIL rd_miso_during_frame got %0d exp 0", miso_bad); end
    tick();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_miso_wait got %b exp 0", miso); end
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      checks++; if (miso !== exp_bits[i]) begin errors++; $display("FAIL rd_miso_bit%0d got %b exp %b", i, miso, exp_bits[i]); end
      tick();
    end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_miso_after got %b exp 0", miso); end
    checks++; if (dut.rd_addr_seen_q !== 1'b0) begin errors++; $display("FAIL rd_addr_seen_clear got %b exp 0", dut.rd_addr_seen_q); end
    // second tx_valid pulse is ignored
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_second_pulse_miso got %b exp 0", miso); end
    end_frame();
  endtask

  task automatic test_abort();
    logic [4:0] bits;
    int seen_valid;
    bits = 5'b01111;
    seen_valid = 0;
    ss_n = 1'b0;
    tick();
    for (int i = 4; i >= 0; i--) begin
      mosi = bits[i];
      tick();
      if (rx_valid) seen_valid++;
    end
    ss_n = 1'b1;
    tick();
    if (rx_valid) seen_valid++;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ab_idle got %0d exp %0d", dut.state_q, IDLE); end
    tick();
    if (rx_valid) seen_valid++;
    checks++; if (seen_valid !== 0) begin errors++; $display("FAIL ab_no_valid got %0d exp 0", seen_valid); end
    checks++; if (rx_data !== 10'h355) begin errors++; $display("FAIL ab_rx_data_hold got %h exp 355", rx_data); end
    send_frame(10'b01_1111_1111);
    checks++; if (route !== WRITE) begin errors++; $display("FAIL ab_next_route got %0d exp %0d", route, WRITE); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ab_next_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 10'h1FF) begin errors++; $display("FAIL ab_next_rx_data got %h exp 1ff", rx_data); end
    end_frame();
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] exp_bits;
    exp_bits = 8'h5A;
    send_frame(10'b10_0001_0001);
    end_frame();
    send_frame(10'b11_0000_0000);
    checks++; if (route !== READ_DATA) begin errors++; $display("FAIL rm_route got %0d exp %0d", route, READ_DATA); end
    tick();
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      checks++; if (miso !== exp_bits[i]) begin errors++; $display("FAIL rm_miso_bit%0d got %b exp %b", i, miso, exp_bits[i]); end
      tick();
    end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rm_miso_bit3 got %b exp 1", miso); end
    rst = 1'b1; ss_n = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rm_miso_reset got %b exp 0", miso); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rm_idle got %0d exp %0d", dut.state_q, IDLE); end
    checks++; if (dut.rd_addr_seen_q !== 1'b0) begin errors++; $display("FAIL rm_rd_addr_seen got %b exp 0", dut.rd_addr_seen_q); end
    send_frame(10'b10_1010_1010);
    checks++; if (route !== READ_ADD) begin errors++; $display("FAIL rm_next_route got %0d exp %0d", route, READ_ADD); end
    checks++; if (rx_data !== 10'h2AA) begin errors++; $display("FAIL rm_next_rx_data got %h exp 2aa", rx_data); end
    end_frame();
  endtask

  task automatic test_spurious_tx();
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL sp_idle_miso got %b exp 0", miso); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL sp_idle_state got %0d exp %0d", dut.state_q, IDLE); end
    send_frame(10'b00_0101_1010);
    checks++; if (miso_bad !== 0) begin errors++; $display("FAIL sp_write_miso got %0d high cycles exp 0", miso_bad); end
    checks++; if (route !== WRITE) begin errors++; $display("FAIL sp_route got %0d exp %0d", route, WRITE); end
    tick();
    checks++; if (dut.state_q !== WRITE) begin errors++; $display("FAIL sp_write_state got %0d exp %0d", dut.state_q, WRITE); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL sp_post_miso got %b exp 0", miso); end
    tx_valid = 1'b0;
    end_frame();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read();
    test_abort();
    test_reset_mid_shift();
    test_spurious_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front-end that deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the dual-port RAM.
- Serialises the RAM's 8-bit read result (tx_data/tx_valid) back onto MISO.
- Sits between the external SPI pins and the RAM inside the SPI wrapper.
- The SPI serial clock is clk; MOSI is sampled and MISO is driven on clk rising edges.

Parameters:
- FRAME_BITS, 10, bits per received command frame (2 command bits + 8 payload bits).
- DATA_BITS, 8, bits per read-data word shifted out on MISO.

Ports:
- clk  input  1  system/SPI clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low; high aborts any frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  FRAME_BITS  assembled command word {cmd[1:0], payload[7:0]}.
- rx_valid  output  1  one-cycle strobe; rx_data is valid with it.
- tx_data  input  DATA_BITS  read data from the RAM.
- tx_valid  input  1  RAM strobe; tx_data is valid when high.

Behaviour:
- Reset: one clock, synchronous, active-high, as decided.
  - State=IDLE; MISO=0, rx_data=0, rx_valid=0.
  - Bit counter=0; rd_addr_seen flag=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA (enum from package).
- IDLE: SS_n=0 moves to CHK_CMD; otherwise stay.
- CHK_CMD (the first frame cycle):
  - MOSI is sampled as frame bit 9 and shifted in.
  - MOSI=0 goes to WRITE.
  - MOSI=1 with rd_addr_seen=0 goes to READ_ADD.
  - MOSI=1 with rd_addr_seen=1 goes to READ_DATA.
- WRITE, READ_ADD, READ_DATA shifting:
  - Shift MOSI in MSB-first for the remaining 9 bits, one bit per cycle.
  - The full frame is 10 consecutive cycles, starting at CHK_CMD.
- rx_valid:
  - Registered; high for exactly one cycle, the cycle after bit 0 is sampled.
  - rx_data holds the full frame while rx_valid is high and holds until the next rx_valid or reset.
  - rx_data[9:8] are passed verbatim; the state routing does not alter them.
- Bits after the 10th are ignored until SS_n returns high; no second rx_valid in the same SS_n-low period.
- READ_ADD: on frame completion, set rd_addr_seen=1.
- READ_DATA, after rx_valid:
  - Wait any number of cycles for tx_valid=1.
  - On that cycle, latch tx_data.
  - MISO drives bit 7 starting the next cycle, then bits 6..0, one per cycle.
  - After bit 0, MISO=0 and rd_addr_seen is cleared.
  - tx_valid seen at any other time (other states, or a second pulse) is ignored.
- MISO is 0 in every state except during the 8-bit READ_DATA shift-out.
- SS_n=1 in any non-IDLE state:
  - Next cycle state=IDLE; bit counter and shift-out abort; MISO=0.
  - No rx_valid is issued for a partial frame.
  - rd_addr_seen is kept unless the READ_DATA shift-out completed.
- SS_n low for longer than needed: remain in current state, idle, until SS_n high.
- A new frame requires SS_n high for at least 1 cycle (the return through IDLE).

Decomposition:
- Package spi_pkg:
  - state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - FRAME_BITS and DATA_BITS defaults.
  - Command codes: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
- One natural sub-module, spi_miso_shifter:
  - Handles the load on tx_valid, the 8-cycle MSB-first shift and the done flag.
  - Instantiated only in spi_slave_if.

Test Plan:
- Write address: SS_n low, MOSI bits 00_1010_0101 -> rx_valid one cycle after bit 0 with rx_data=10'h0A5; MISO=0 throughout; state IDLE one cycle after SS_n high.
- Write data: frame 01_0011_1100 -> rx_valid with rx_data=10'h13C; rd_addr_seen stays 0.
- Read address then read data:
  - Frame 10_0000_0111 -> rx_data=10'h207, rd_addr_seen=1.
  - Next frame 11_xxxx_xxxx -> state READ_DATA, rx_data=10'h3xx.
  - tx_valid=1 with tx_data=8'hC3 two cycles later -> MISO sequence 1,1,0,0,0,0,1,1 on the following 8 cycles, then 0; rd_addr_seen cleared.
- Abort: SS_n raised after 5 bits of a write frame -> no rx_valid, IDLE next cycle; next full frame 01_1111_1111 -> rx_data=10'h1FF.
- Reset mid-shift: rst=1 during MISO bit 3 of a read -> next cycle MISO=0, state IDLE, rd_addr_seen=0; a subsequent frame starting with 1 routes to READ_ADD.
- Spurious tx_valid: tx_valid=1 in WRITE and in IDLE -> MISO stays 0, no state change.
